// File: rtl/flags_register_pkg.sv
// Shared constants for the flags register: flag bit positions and condition-select codes.
package flags_register_pkg;

  localparam int FLAG_W  = 5;
  localparam int FLAG_V  = 0;
  localparam int FLAG_S  = 1;
  localparam int FLAG_Z  = 2;
  localparam int FLAG_CA = 3;
  localparam int FLAG_CL = 4;

  typedef enum logic [3:0] {
    COND_ALWAYS = 4'd0,
    COND_NEVER  = 4'd1,
    COND_Z      = 4'd2,
    COND_NZ     = 4'd3,
    COND_CA     = 4'd4,
    COND_NCA    = 4'd5,
    COND_S      = 4'd6,
    COND_NS     = 4'd7,
    COND_V      = 4'd8,
    COND_NV     = 4'd9,
    COND_CL     = 4'd10,
    COND_NCL    = 4'd11,
    COND_LT     = 4'd12,
    COND_GE     = 4'd13,
    COND_UGT    = 4'd14,
    COND_ULE    = 4'd15
  } cond_e;

endpackage

// File: rtl/flags_register_cond_eval.sv
// Combinational condition evaluator: flag vector plus condition select -> single taken bit.
module cond_eval
  import flags_register_pkg::*;
(
  input  logic [FLAG_W-1:0] flags,
  input  logic [3:0]        cond_sel,
  output logic              result
);

  logic v, s, z, ca, cl;

  assign v  = flags[FLAG_V];
  assign s  = flags[FLAG_S];
  assign z  = flags[FLAG_Z];
  assign ca = flags[FLAG_CA];
  assign cl = flags[FLAG_CL];

  always_comb begin
    result = 1'b0;
    case (cond_e'(cond_sel))
      COND_ALWAYS: result = 1'b1;
      COND_NEVER:  result = 1'b0;
      COND_Z:      result = z;
      COND_NZ:     result = ~z;
      COND_CA:     result = ca;
      COND_NCA:    result = ~ca;
      COND_S:      result = s;
      COND_NS:     result = ~s;
      COND_V:      result = v;
      COND_NV:     result = ~v;
      COND_CL:     result = cl;
      COND_NCL:    result = ~cl;
      COND_LT:     result = s ^ v;
      COND_GE:     result = ~(s ^ v);
      COND_UGT:    result = ca & ~z;
      COND_ULE:    result = ~ca | z;
      default:     result = 1'b0;
    endcase
  end

endmodule

// File: rtl/flags_register.sv
// CPU flags register with bus save/restore and a one-cycle condition evaluator.
// FLAGS_BYPASS_EN: when defined, conditions see the flag value being loaded in the same cycle.
module flags_register
  import flags_register_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [FLAG_W-1:0] AluFlags,
  input  logic              FlagsLoadAlu,
  input  logic              FlagsLoadBus,
  input  logic              FlagsAssert,
  inout  wire  [7:0]        MainBus,
  output logic [FLAG_W-1:0] Flags,
  output logic              LCarryIn,
  input  logic [3:0]        CondSel,
  input  logic              CondValid,
  output logic              Taken,
  output logic              TakenValid
);

  logic [FLAG_W-1:0] flags_next;
  logic [FLAG_W-1:0] eval_flags;
  logic              cond_result;
  logic [2:0]        unused_bus_hi;

  assign unused_bus_hi = MainBus[7:5];

  // Bus restore has priority over the ALU so a flags pop is never lost.
  always_comb begin
    flags_next = Flags;
    if (FlagsLoadBus)
      flags_next = MainBus[FLAG_W-1:0];
    else if (FlagsLoadAlu)
      flags_next = AluFlags;
  end

`ifdef FLAGS_BYPASS_EN
  assign eval_flags = flags_next;
`else
  assign eval_flags = Flags;
`endif

  cond_eval u_cond_eval (
    .flags    (eval_flags),
    .cond_sel (CondSel),
    .result   (cond_result)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Flags      <= '0;
      Taken      <= 1'b0;
      TakenValid <= 1'b0;
    end else begin
      Flags      <= flags_next;
      TakenValid <= CondValid;
      if (CondValid)
        Taken <= cond_result;
    end
  end

  assign LCarryIn = Flags[FLAG_CL];

  // Never drive the shared bus while held in reset.
  assign MainBus = (FlagsAssert && Reset_n) ? {3'b000, Flags} : 8'hzz;

endmodule

// File: tb/tb_flags_register.sv
// Directed bench for flags_register: behavioural model checked every cycle plus literal expectations.
module tb_flags_register;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic [4:0] AluFlags;
  logic       FlagsLoadAlu, FlagsLoadBus, FlagsAssert;
  logic [4:0] Flags;
  logic       LCarryIn;
  logic [3:0] CondSel;
  logic       CondValid;
  logic       Taken, TakenValid;
  logic       tb_drive;
  logic [7:0] tb_bus;
  wire  [7:0] MainBus;

  int tests = 0;
  int fails = 0;

  // Model state: what the registered outputs must be.
  logic [4:0] m_flags;
  logic       m_taken, m_tv;

  assign MainBus = tb_drive ? tb_bus : 8'hzz;

  always #5 Clock = ~Clock;

  flags_register dut (
    .Clock(Clock), .Reset_n(Reset_n), .AluFlags(AluFlags),
    .FlagsLoadAlu(FlagsLoadAlu), .FlagsLoadBus(FlagsLoadBus),
    .FlagsAssert(FlagsAssert), .MainBus(MainBus), .Flags(Flags),
    .LCarryIn(LCarryIn), .CondSel(CondSel), .CondValid(CondValid),
    .Taken(Taken), .TakenValid(TakenValid)
  );

  // Conditions come in true/inverted pairs: even code = predicate, odd code = its negation.
  function automatic logic model_cond(input int sel, input logic [4:0] f);
    logic v, s, z, ca, cl, base;
    v = f[0]; s = f[1]; z = f[2]; ca = f[3]; cl = f[4];
    case (sel / 2)
      0: base = 1'b1;
      1: base = z;
      2: base = ca;
      3: base = s;
      4: base = v;
      5: base = cl;
      6: base = (s != v);
      default: base = ca && !z;
    endcase
    return (sel % 2 == 1) ? !base : base;
  endfunction

  always @(posedge Clock or negedge Reset_n) begin
    logic [4:0] nxt, bus_val;
    if (!Reset_n) begin
      m_flags = 5'd0; m_taken = 1'b0; m_tv = 1'b0;
    end else begin
      bus_val = tb_drive ? tb_bus[4:0] : (FlagsAssert ? m_flags : 5'd0);
      nxt = FlagsLoadBus ? bus_val : (FlagsLoadAlu ? AluFlags : m_flags);
      if (CondValid) begin
`ifdef FLAGS_BYPASS_EN
        m_taken = model_cond(int'(CondSel), nxt);
`else
        m_taken = model_cond(int'(CondSel), m_flags);
`endif
      end
      m_tv = CondValid;
      m_flags = nxt;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: registered outputs against the model.
  always @(negedge Clock) begin
    check("model_flags", {3'b0, Flags}, {3'b0, m_flags});
    check("model_lcarry", {7'b0, LCarryIn}, {7'b0, m_flags[4]});
    check("model_taken", {7'b0, Taken}, {7'b0, m_taken});
    check("model_tv", {7'b0, TakenValid}, {7'b0, m_tv});
  end

  task automatic cyc();
    @(negedge Clock);
    #1;
  endtask

  task automatic idle();
    FlagsLoadAlu = 0; FlagsLoadBus = 0; FlagsAssert = 0;
    CondValid = 0; tb_drive = 0;
  endtask

  task automatic load_alu(input logic [4:0] f);
    AluFlags = f; FlagsLoadAlu = 1;
    cyc();
    FlagsLoadAlu = 0;
  endtask

  task automatic cond(input logic [3:0] sel);
    CondSel = sel; CondValid = 1;
    cyc();
    CondValid = 0;
  endtask

  initial begin
    Reset_n = 0; AluFlags = 0; CondSel = 0; tb_bus = 8'h00;
    idle();
    // In reset with FlagsAssert high the DUT must leave the bus to the bench.
    FlagsAssert = 1; tb_drive = 1; tb_bus = 8'hA5; CondValid = 1;
    #3;
    check("reset_bus", MainBus, 8'hA5);
    check("reset_flags", {3'b0, Flags}, 8'h00);
    check("reset_taken", {7'b0, Taken}, 8'h00);
    check("reset_tv", {7'b0, TakenValid}, 8'h00);
    cyc(); cyc();
    idle();
    Reset_n = 1;
    cyc();

    // Zero flag set by ALU, then Z / !Z.
    load_alu(5'b00100);
    check("alu_load_z", {3'b0, Flags}, 8'h04);
    cond(4'd2);
    check("cond_z_taken", {7'b0, Taken}, 8'h01);
    check("cond_z_tv", {7'b0, TakenValid}, 8'h01);
    cond(4'd3);
    check("cond_nz_taken", {7'b0, Taken}, 8'h00);
    cyc();
    check("tv_drops", {7'b0, TakenValid}, 8'h00);
    check("taken_holds", {7'b0, Taken}, 8'h00);

    // Save flags to bus, then restore with both loads asserted: bus wins.
    load_alu(5'b00010);
    FlagsAssert = 1;
    #1;
    check("assert_bus", MainBus, 8'h02);
    FlagsAssert = 0; tb_drive = 1; tb_bus = 8'h19;
    FlagsLoadBus = 1; FlagsLoadAlu = 1; AluFlags = 5'b00000;
    cyc();
    idle();
    check("bus_wins", {3'b0, Flags}, 8'h19);
    check("lcarry", {7'b0, LCarryIn}, 8'h01);
    // Assert and restore together must keep the value.
    FlagsAssert = 1; FlagsLoadBus = 1;
    cyc();
    check("assert_reload", {3'b0, Flags}, 8'h19);
    idle();

    // Signed and unsigned compares.
    load_alu(5'b00011);
    cond(4'd12);
    check("lt_sv", {7'b0, Taken}, 8'h00);
    load_alu(5'b00010);
    cond(4'd12);
    check("lt_s", {7'b0, Taken}, 8'h01);
    load_alu(5'b01000);
    cond(4'd14);
    check("ugt_ca", {7'b0, Taken}, 8'h01);
    load_alu(5'b01100);
    cond(4'd14);
    check("ugt_caz", {7'b0, Taken}, 8'h00);

    // Load and evaluate in the same cycle.
    load_alu(5'b00000);
    AluFlags = 5'b00100; FlagsLoadAlu = 1; CondSel = 4'd2; CondValid = 1;
    cyc();
    idle();
`ifdef FLAGS_BYPASS_EN
    check("same_cycle_z", {7'b0, Taken}, 8'h01);
`else
    check("same_cycle_z", {7'b0, Taken}, 8'h00);
`endif

    // Sweep every flag value and condition with CondValid held high.
    CondValid = 1;
    for (int f = 0; f < 32; f++) begin
      AluFlags = 5'(f); FlagsLoadAlu = 1; CondSel = 4'd0;
      cyc();
      FlagsLoadAlu = 0;
      for (int s = 0; s < 16; s++) begin
        CondSel = 4'(s);
        cyc();
        check("sweep_tv", {7'b0, TakenValid}, 8'h01);
      end
    end

    // Evaluation in flight when reset hits must be discarded.
    CondSel = 4'd0;
    @(posedge Clock);
    #2;
    Reset_n = 0;
    #1;
    check("rst_async_tv", {7'b0, TakenValid}, 8'h00);
    check("rst_async_flags", {3'b0, Flags}, 8'h00);
    idle();
    cyc();
    Reset_n = 1;
    cyc(); cyc();
    check("post_rst_tv", {7'b0, TakenValid}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
